// File: rtl/gray_fifo_writer_if.sv
// Handshake bundle between the RGB source FIFO, the gray sink FIFO and the writer.
// master = writer side, slave = FIFO/bench side.
interface gray_fifo_writer_if;
  logic        in_rd_en;
  logic [23:0] in_dout;
  logic        in_empty;
  logic        out_wr_en;
  logic [7:0]  out_din;
  logic        out_full;
  logic        frame_done;

  modport master (
    output in_rd_en,
    input  in_dout,
    input  in_empty,
    output out_wr_en,
    output out_din,
    input  out_full,
    output frame_done
  );

  modport slave (
    input  in_rd_en,
    output in_dout,
    output in_empty,
    input  out_wr_en,
    input  out_din,
    output out_full,
    input  frame_done
  );
endinterface

// File: rtl/gray_fifo_writer.sv
// RGB-to-luma FIFO bridge with raster tracking and end-of-frame pulse.
// One pixel in flight: pop in S_READ, push in S_WRITE.
module gray_fifo_writer #(
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540
) (
  input  logic               clock,
  input  logic               reset,
  gray_fifo_writer_if.master bus_if
);

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam logic [12:0] XLast = 13'(IMG_WIDTH - 1);
  localparam logic [12:0] YLast = 13'(IMG_HEIGHT - 1);

  state_t      state_q, state_d;
  logic [12:0] x_q, x_d;
  logic [12:0] y_q, y_d;
  logic [7:0]  gray_q, gray_d;
  logic        last_q, last_d;

  logic [7:0]  r, g, b;
  logic [15:0] sum;
  logic        x_end, y_end;

  assign r = bus_if.in_dout[23:16];
  assign g = bus_if.in_dout[15:8];
  assign b = bus_if.in_dout[7:0];

  // Max 255*256 = 65280, so 16 bits never overflow.
  assign sum = 16'd77  * {8'd0, r}
             + 16'd150 * {8'd0, g}
             + 16'd29  * {8'd0, b};

  assign x_end = (x_q == XLast);
  assign y_end = (y_q == YLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_READ;
      x_q     <= '0;
      y_q     <= '0;
      gray_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      gray_q  <= gray_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    x_d               = x_q;
    y_d               = y_q;
    gray_d            = gray_q;
    last_d            = last_q;
    bus_if.in_rd_en   = 1'b0;
    bus_if.out_wr_en  = 1'b0;
    bus_if.frame_done = 1'b0;
    case (state_q)
      S_READ: begin
        if (!reset && !bus_if.in_empty) begin
          bus_if.in_rd_en = 1'b1;
          gray_d          = sum[15:8];
          last_d          = x_end && y_end;
          x_d             = x_end ? '0 : x_q + 13'd1;
          if (x_end)
            y_d = y_end ? '0 : y_q + 13'd1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!reset && !bus_if.out_full) begin
          bus_if.out_wr_en  = 1'b1;
          bus_if.frame_done = last_q;
          state_d           = S_READ;
        end
      end
      default: state_d = S_READ;
    endcase
  end

  assign bus_if.out_din = gray_q;

endmodule
